// File: rtl/rx_axis_buffer.sv
// rx_axis_buffer: elastic RX FIFO to an AXI4-Stream master; truncates or drops packets on overflow
module rx_axis_buffer #(
  parameter int DEPTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [111:0]     rx_tdata,
  input  logic [13:0]      rx_tkeep,
  input  logic             rx_tlast,
  input  logic             rx_valid,
  output logic [111:0]     m_axis_tdata,
  output logic [13:0]      m_axis_tkeep,
  output logic             m_axis_tlast,
  output logic             m_axis_tuser,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int W = 128;
  typedef enum logic {PASS, DROP} state_t;
  state_t state, state_nxt;
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] hold;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt, free;
  logic sop, wr, trunc, ovf, pop;
  assign free = (AW+1)'(DEPTH) - cnt;
  assign pop = m_axis_tvalid & m_axis_tready;
  assign m_axis_tvalid = cnt != 0;
  // Empty FIFO keeps showing the last beat handed downstream
  assign {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata} = m_axis_tvalid ? mem[rd_ptr] : hold;
  always_comb begin
    state_nxt = state;
    wr = 1'b0;
    trunc = 1'b0;
    ovf = 1'b0;
    if (rx_valid) begin
      if (state == DROP) state_nxt = rx_tlast ? PASS : DROP;
      else if (free == 0) begin
        ovf = 1'b1;
        state_nxt = rx_tlast ? PASS : DROP;
      end else if (free == 1 && !rx_tlast) begin
        wr = 1'b1;
        trunc = 1'b1;
        ovf = 1'b1;
        state_nxt = DROP;
      end else wr = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= PASS;
      sop <= 1'b1;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      hold <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (rx_valid) sop <= rx_tlast;
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        hold <= mem[rd_ptr];
      end
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(pop);
      overflow <= ovf;
      if (ovf && !(&drop_cnt)) drop_cnt <= drop_cnt + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (wr && rst_n) mem[wr_ptr] <= {trunc, rx_tlast | trunc, rx_tkeep, rx_tdata};
  end
  // A mid-packet beat always leaves at least one free slot behind it
  always_ff @(posedge clk) begin
    if (rst_n && rx_valid && state == PASS && !sop) assert (free != 0);
  end
endmodule

// File: tb/tb_rx_axis_buffer.sv
// tb_rx_axis_buffer: scoreboard bench for rx_axis_buffer covering passthrough, backpressure, overflow and saturation
module tb_rx_axis_buffer;
  localparam int D = 8;
  logic clk, rst_n;
  logic [111:0] rx_tdata, m_axis_tdata;
  logic [13:0] rx_tkeep, m_axis_tkeep;
  logic rx_tlast, rx_valid, m_axis_tlast, m_axis_tuser, m_axis_tvalid, m_axis_tready, overflow;
  logic [15:0] drop_cnt;
  logic [127:0] q[$];
  logic [127:0] last_out = '0;
  logic [15:0] exp_drop = '0;
  logic exp_ovf = 1'b0;
  logic m_drop = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  rx_axis_buffer #(.DEPTH(D), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_tdata(rx_tdata), .rx_tkeep(rx_tkeep), .rx_tlast(rx_tlast), .rx_valid(rx_valid),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .drop_cnt(drop_cnt), .overflow(overflow)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  // Reference model: judges each beat against the occupancy before this cycle's pop
  always @(negedge clk) begin
    int free;
    logic ovf;
    chk("tvalid", m_axis_tvalid, q.size() != 0);
    chk("beat", {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata}, q.size() != 0 ? q[0] : last_out);
    chk("overflow", overflow, exp_ovf);
    chk("drop_cnt", drop_cnt, exp_drop);
    if (!rst_n) begin
      q.delete();
      last_out = '0;
      exp_drop = '0;
      exp_ovf = 1'b0;
      m_drop = 1'b0;
    end else begin
      free = D - q.size();
      ovf = 1'b0;
      if (q.size() != 0 && m_axis_tready) last_out = q.pop_front();
      if (rx_valid) begin
        if (m_drop) m_drop = !rx_tlast;
        else if (free == 0) begin
          ovf = 1'b1;
          m_drop = !rx_tlast;
        end else if (free == 1 && !rx_tlast) begin
          ovf = 1'b1;
          m_drop = 1'b1;
          q.push_back({2'b11, rx_tkeep, rx_tdata});
        end else q.push_back({1'b0, rx_tlast, rx_tkeep, rx_tdata});
      end
      exp_ovf = ovf;
      if (ovf && exp_drop != 16'hFFFF) exp_drop++;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(int n);
    repeat (n) tick();
  endtask
  task automatic send(logic [13:0] keep, logic last);
    rx_valid = 1'b1;
    rx_tdata = 112'({$urandom, $urandom, $urandom, $urandom});
    rx_tkeep = keep;
    rx_tlast = last;
    tick();
    rx_valid = 1'b0;
  endtask
  task automatic pkt(int n);
    for (int i = 0; i < n; i++) send(14'h3FFF, i == n - 1);
  endtask
  initial begin
    rst_n = 1'b0;
    m_axis_tready = 1'b0;
    rx_valid = 1'b0;
    rx_tdata = '0;
    rx_tkeep = '0;
    rx_tlast = 1'b0;
    idle(3);
    rst_n = 1'b1;
    m_axis_tready = 1'b1;
    send(14'h3FFF, 1'b0);
    send(14'h3FFF, 1'b0);
    send(14'h3F00, 1'b1);
    idle(3);
    chk("t2_drop", drop_cnt, 0);
    send(14'h3FFF, 1'b0);
    send(14'h3FFF, 1'b0);
    rst_n = 1'b0;
    send(14'h3FFF, 1'b0);
    rst_n = 1'b1;
    chk("t1_rst_valid", m_axis_tvalid, 0);
    chk("t1_rst_out", {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata}, 0);
    pkt(2);
    idle(3);
    m_axis_tready = 1'b0;
    pkt(5);
    idle(3);
    chk("t3_valid", m_axis_tvalid, 1);
    m_axis_tready = 1'b1;
    idle(7);
    m_axis_tready = 1'b0;
    pkt(D + 2);
    chk("t4_drop", drop_cnt, 1);
    m_axis_tready = 1'b1;
    idle(2);
    pkt(2);
    idle(D + 2);
    m_axis_tready = 1'b0;
    pkt(D);
    pkt(2);
    pkt(1);
    idle(1);
    chk("t5_drop", drop_cnt, 3);
    m_axis_tready = 1'b1;
    send(14'h3FFF, 1'b1);
    m_axis_tready = 1'b0;
    chk("t6_drop", drop_cnt, 4);
    send(14'h3FFF, 1'b1);
    repeat (65531) send(14'h3FFF, 1'b1);
    chk("sat_reach", drop_cnt, 16'hFFFF);
    send(14'h3FFF, 1'b1);
    send(14'h3FFF, 1'b1);
    chk("sat_hold", drop_cnt, 16'hFFFF);
    m_axis_tready = 1'b1;
    for (int i = 0; i < 100 && m_axis_tvalid; i++) tick();
    chk("drain", m_axis_tvalid, 0);
    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
